tempo_beat_gen: RTL

TEMPO_BEAT_GEN -- requirements
Module: tempo_beat_gen

---
 rtl/tempo_beat_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/tempo_beat_gen.sv
// rtl/tempo_beat_gen.sv - Phase-accumulator metronome emitting tick/beat/bar pulses
// Optional macro TEMPO_BPM_CLAMP_EN clamps bpm into [BPM_MIN, BPM_MAX].
module tempo_beat_gen #(
  parameter int CLK_HZ   = 100000000,
  parameter int BPM_W    = 9,
  parameter int SUB_LOG2 = 2,
  parameter int BEAT_W   = 4,
  parameter int BPM_MIN  = 30,
  parameter int BPM_MAX  = 300
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                sync,
  input  logic [BPM_W-1:0]    bpm,
  input  logic [BEAT_W-1:0]   beats_per_bar,
  output logic                tick,
  output logic                beat,
  output logic                bar,
  output logic [SUB_LOG2-1:0] sub_idx,
  output logic [BEAT_W-1:0]   beat_idx,
  output logic                active
);

  localparam logic [63:0] PERIOD  = 64'(CLK_HZ) * 64'd60;
  localparam logic [63:0] INC_MAX = ((64'd1 << BPM_W) - 64'd1) << SUB_LOG2;
  localparam int          ACC_W   = $clog2(PERIOD + INC_MAX + 64'd1);
  localparam logic [ACC_W-1:0] P_ACC = PERIOD[ACC_W-1:0];

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [SUB_LOG2-1:0] sub_q, sub_d;
  logic [BEAT_W-1:0]   beat_idx_q, beat_idx_d;
  logic                tick_q, tick_d;
  logic                beat_q, beat_d;
  logic                bar_q, bar_d;
  logic                active_q, active_d;

  logic [BPM_W-1:0]    bpm_eff;
  logic [ACC_W-1:0]    inc;
  logic [ACC_W-1:0]    sum;
  logic [BEAT_W-1:0]   last_beat;
  logic                start;

  always_comb begin
`ifdef TEMPO_BPM_CLAMP_EN
    if (32'(bpm) < BPM_MIN) begin
      bpm_eff = BPM_W'(BPM_MIN);
    end else if (32'(bpm) > BPM_MAX) begin
      bpm_eff = BPM_W'(BPM_MAX);
    end else begin
      bpm_eff = bpm;
    end
`else
    bpm_eff = bpm;
`endif
  end

  // ACC_W is sized so acc (< P) plus the largest increment never wraps.
  assign inc       = ACC_W'(bpm_eff) << SUB_LOG2;
  assign sum       = acc_q + inc;
  assign last_beat = (beats_per_bar == '0) ? '0 : beats_per_bar - 1'b1;
  assign start     = run && (!active_q || sync);

  always_comb begin
    acc_d      = acc_q;
    sub_d      = sub_q;
    beat_idx_d = beat_idx_q;
    tick_d     = 1'b0;
    beat_d     = 1'b0;
    bar_d      = 1'b0;
    active_d   = run;
    if (!run) begin
      acc_d      = '0;
      sub_d      = '0;
      beat_idx_d = '0;
    end else if (start) begin
      acc_d      = '0;
      sub_d      = '0;
      beat_idx_d = '0;
      tick_d     = 1'b1;
      beat_d     = 1'b1;
      bar_d      = 1'b1;
    end else if (sum >= P_ACC) begin
      acc_d  = sum - P_ACC;
      tick_d = 1'b1;
      sub_d  = sub_q + 1'b1;
      if (sub_q == '1) begin
        beat_d = 1'b1;
        // >= rather than == so a mid-bar shrink of beats_per_bar still closes the bar
        if (beat_idx_q >= last_beat) begin
          beat_idx_d = '0;
          bar_d      = 1'b1;
        end else begin
          beat_idx_d = beat_idx_q + 1'b1;
        end
      end
    end else begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      sub_q      <= '0;
      beat_idx_q <= '0;
      tick_q     <= 1'b0;
      beat_q     <= 1'b0;
      bar_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      sub_q      <= sub_d;
      beat_idx_q <= beat_idx_d;
      tick_q     <= tick_d;
      beat_q     <= beat_d;
      bar_q      <= bar_d;
      active_q   <= active_d;
    end
  end

  assign tick     = tick_q;
  assign beat     = beat_q;
  assign bar      = bar_q;
  assign sub_idx  = sub_q;
  assign beat_idx = beat_idx_q;
  assign active   = active_q;

endmodule
